// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I instruction fields into a 32-bit word and buffers
// the result in a 2-entry FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   inValid / inReady   input handshake for one field set
//   fmt                 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6-7 illegal
//   opcode, rd, rs1, rs2, fn3, fn7, imm   instruction fields
//   outValid / outReady output handshake, instOut is the oldest buffered word
//   errIll              sticky: an illegal fmt was handshaken
//   errImm              sticky: an enqueued immediate was out of range
//   clrErr              clears both sticky flags (a same-cycle set wins)
//   encCount            wrapping count of enqueued words
//
// Build option: define IMM_CHECK_EN to build the immediate range check;
// otherwise errImm is tied low.
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  output logic        inReady,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  fn3,
  input  logic [6:0]  fn7,
  input  logic [31:0] imm,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] instOut,
  output logic        errIll,
  output logic        errImm,
  input  logic        clrErr,
  output logic [15:0] encCount
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_head;
  logic [31:0] r_tail;
  logic [31:0] w_word;
  logic        r_hold;
  logic        r_err_ill;
  logic [15:0] r_count;
  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // r_hold is set by reset and clears on the first edge after release, so no
  // handshake can complete on that edge. inReady still reads 1 while rst is high.
  assign inReady  = (r_state != StTwo) && (rst || !r_hold);
  assign outValid = (r_state != StEmpty);
  assign instOut  = r_head;
  assign errIll   = r_err_ill;
  assign encCount = r_count;

  assign w_legal  = (fmt < 3'd6);
  assign w_accept = inValid && inReady && !r_hold;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = outValid && outReady && !r_hold;

  // Field packing
  always_comb begin
    w_word = 32'h0000_0000;
    case (fmt)
      3'd0: w_word = {fn7, rs2, rs1, fn3, rd, opcode};
      3'd1: w_word = {imm[11:0], rs1, fn3, rd, opcode};
      3'd2: w_word = {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode};
      3'd3: w_word = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], opcode};
      3'd4: w_word = {imm[31:12], rd, opcode};
      3'd5: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_word = 32'h0000_0000;
    endcase
  end

  // Occupancy FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StEmpty: begin
        if (w_push) w_state_nxt = StOne;
      end
      StOne: begin
        if (w_push && !w_pop)      w_state_nxt = StTwo;
        else if (!w_push && w_pop) w_state_nxt = StEmpty;
      end
      StTwo: begin
        if (w_pop) w_state_nxt = StOne;
      end
      default: w_state_nxt = StEmpty;
    endcase
  end

  // FIFO storage: r_head is always the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= 32'h0000_0000;
      r_tail <= 32'h0000_0000;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_push) r_head <= w_word;
        end
        StOne: begin
          // Push and pop together: the new word becomes the only entry.
          if (w_push && w_pop) r_head <= w_word;
          else if (w_push)     r_tail <= w_word;
        end
        StTwo: begin
          if (w_pop) r_head <= r_tail;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold    <= 1'b1;
      r_err_ill <= 1'b0;
      r_count   <= 16'h0000;
    end else begin
      r_hold <= 1'b0;
      if (w_accept && !w_legal) r_err_ill <= 1'b1;
      else if (clrErr)          r_err_ill <= 1'b0;
      if (w_push) r_count <= r_count + 16'd1;
    end
  end

`ifdef IMM_CHECK_EN
  logic w_imm_bad;
  logic r_err_imm;

  // Signed range test: all bits above the field's sign bit equal the sign bit.
  always_comb begin
    w_imm_bad = 1'b0;
    case (fmt)
      3'd1, 3'd2: w_imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
      3'd3:       w_imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      3'd4:       w_imm_bad = |imm[11:0];
      3'd5:       w_imm_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:    w_imm_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_imm <= 1'b0;
    end else if (w_push && w_imm_bad) begin
      r_err_imm <= 1'b1;
    end else if (clrErr) begin
      r_err_imm <= 1'b0;
    end
  end

  assign errImm = r_err_imm;
`else
  assign errImm = 1'b0;
`endif

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst, which is asynchronous and active-high.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- inValid  in  1  field set presented.
- inReady  out  1  encoder can accept a field set.
- fmt  in  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6-7 illegal.
- opcode  in  7  opcode field.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- fn3  in  3  funct3 field.
- fn7  in  7  funct7 field.
- imm  in  32  immediate, byte-offset form, sign-extended.
- outValid  out  1  encoded word available.
- outReady  in  1  consumer takes the word.
- instOut  out  32  encoded RV32I instruction word.
- errIll  out  1  sticky illegal-format flag.
- errImm  out  1  sticky immediate-range flag.
- clrErr  in  1  clears both sticky flags.
- encCount  out  16  count of enqueued instructions.

Function
REQ-003 The transfer handshake SHALL be as follows: an input transfer occurs when inValid && inReady; an output transfer occurs when outValid && outReady.
REQ-004 Encoded words SHALL be held in a 2-entry FIFO controlled by an occupancy FSM with states EMPTY, ONE and TWO.
REQ-005 inReady SHALL be 1 in EMPTY and ONE, and 0 in TWO; inReady SHALL NOT depend on outReady.
REQ-006 outValid SHALL be 1 in ONE and TWO; instOut SHALL show the oldest entry and SHALL be held stable while outValid && !outReady.
REQ-007 The FSM SHALL move as follows:
- push only: EMPTY->ONE, ONE->TWO.
- pop only: TWO->ONE, ONE->EMPTY.
- push and pop in the same cycle in ONE: stay in ONE, FIFO order kept.
REQ-008 Latency SHALL be one cycle: a word accepted in cycle N with the FIFO empty SHALL appear with outValid=1 in cycle N+1.
REQ-009 Bit placement for each format SHALL be (MSB to LSB):
- R: fn7|rs2|rs1|fn3|rd|opcode.
- I: imm[11:0]|rs1|fn3|rd|opcode.
- S: imm[11:5]|rs2|rs1|fn3|imm[4:0]|opcode.
- B: imm[12]|imm[10:5]|rs2|rs1|fn3|imm[4:1]|imm[11]|opcode.
- U: imm[31:12]|rd|opcode.
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-010 Fields not used by a format SHALL be ignored.
REQ-011 For fmt 6 or 7, the handshake SHALL complete, nothing SHALL be enqueued, encCount SHALL be unchanged, and errIll SHALL be 1 from the next cycle.
REQ-012 errIll and errImm SHALL stay set until clrErr=1; if a set event and clrErr occur in the same cycle, set SHALL win.
REQ-013 encCount SHALL increment by 1 on every enqueue and wrap from 0xFFFF to 0x0000.

Reset
REQ-014 While rst=1, the block SHALL asynchronously force: FSM EMPTY, outValid=0, inReady=1, instOut=0x00000000, errIll=0, errImm=0, encCount=0.
REQ-015 An assertion of rst mid-transfer SHALL discard all FIFO contents.
REQ-016 No handshake SHALL complete in the cycle rst deasserts.

Configuration
REQ-017 Macro IMM_CHECK_EN SHALL control the immediate range check.
REQ-018 With IMM_CHECK_EN defined, errImm SHALL set on an enqueued word whose immediate is out of range for its format; the word SHALL still be enqueued as truncated. Out of range means:
- I and S: imm not representable as 12-bit signed.
- B: imm not 13-bit signed, or imm[0]=1.
- J: imm not 21-bit signed, or imm[0]=1.
- U: imm[11:0]≠0.
REQ-019 Without IMM_CHECK_EN, errImm SHALL be tied to 0 and no check logic SHALL be built.

Verification
REQ-020 Bench SHALL cover: R, op 0x33, rd 18, rs1 9, rs2 8, fn3 0, fn7 0 -> instOut 0x00848933 one cycle later, encCount 1.
REQ-021 Bench SHALL cover: I, op 0x13, rd 9, rs1 0, imm 0x101 -> 0x10100493; then S, op 0x23, rs1 5, rs2 8, fn3 2, imm 4 -> 0x0082a223.
REQ-022 Bench SHALL cover: U, op 0x37, rd 1, imm 0x87237000 -> 0x872370b7; then J, op 0x6f, rd 0, imm 0 -> 0x0000006f.
REQ-023 Bench SHALL cover: outReady=0 and three back-to-back pushes -> inReady falls after the second; with outReady=1, words drain in order and the third is then accepted.
REQ-024 Bench SHALL cover: fmt 7 -> no outValid, encCount unchanged, errIll=1; clrErr pulse -> errIll=0.
REQ-025 Bench SHALL cover, with IMM_CHECK_EN: B, imm 3 -> errImm=1 and the word is still output; rst asserted mid-stream -> all outputs at reset values immediately.
